alu16_mul_seq: RTL and testbench
================================

# alu16_mul_seq

Multi-cycle shift-and-add multiplier sequencer for the ALU16 datapath. It time-shares one instance of the codebase's 16-bit ripple-carry adder (RipAdder8, length=16) between two users: the multiply sequence, and an external ALU port that may use the adder only while the sequencer is idle. The block produces a 32-bit product from two 16-bit operands with a start/busy/done handshake and a fixed latency.

## Interface
Parameters:
- WIDTH, 16, operand width. Only 16 is supported, matching the adder.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request a multiply; sampled only while busy=0
- op_a  in  16  multiplicand, captured on the accepting edge
- op_b  in  16  multiplier, captured on the accepting edge
- busy  out  1  a multiply is in progress
- done  out  1  one-cycle pulse; product is valid
- product  out  32  registered result; holds until the next completion
- ext_a, ext_b  in  16  external adder operands
- ext_cin  in  1  external carry-in
- ext_gnt  out  1  adder granted to external port; equals !busy
- ext_sum  out  16  adder sum when ext_gnt=1, else 0
- ext_cout  out  1  adder carry-out when ext_gnt=1, else 0

## Operation
- Registers: mcand[15:0], hi[15:0], lo[15:0], cnt[3:0], state.
- States: IDLE, ITER. With MUL_SIGNED_EN, the states are IDLE, PRE_A, PRE_B, ITER, POST_LO, POST_HI.
- IDLE to first state: start=1 at an edge. That edge loads mcand=op_a, lo=op_b, hi=0, cnt=0, and sets busy=1.
- ITER cycle:
  - Adder inputs are (hi, lo[0] ? mcand : 0, cin=0).
  - {hi,lo} <= {cout, sum, lo[15:1]}, i.e. the 33-bit value {cout,sum,lo} shifted right by one.
  - cnt increments each cycle. The cycle with cnt=15 is the last.
- Completion:
  - product <= {hi,lo} result.
  - done=1 for exactly one cycle, busy=0, return to IDLE.
- Adder mux: the sequencer drives the adder whenever busy=1. Otherwise ext_a/ext_b/ext_cin drive it combinationally to ext_sum/ext_cout.
- start while busy=1 is ignored. It is not queued and has no effect on the operation in flight.
- start on the same edge as done: this is the IDLE-entry edge, so it is accepted on the next edge only if still asserted. There is no back-to-back acceptance in the done cycle.
- Reset:
  - rst=1 at any edge forces IDLE, busy=0, done=0, product=0, and all internal registers to 0.
  - rst has priority over start.
  - An operation interrupted by reset is discarded.

## Timing
- Accepting edge E0.
- Unsigned: ITER occupies edges E1..E16. busy is high from after E0 through E16. done and a valid product appear after E16, so latency is 16 cycles.
- Signed: PRE_A at E1, PRE_B at E2, ITER at E3..E18, POST_LO at E19, POST_HI at E20. done follows E20, so latency is 20 cycles. This latency is fixed regardless of operand signs.
- ext_gnt, ext_sum and ext_cout are combinational from busy and the ext inputs. The external user sees no registered delay.

## Configuration
- MUL_SIGNED_EN defined: operands are two's complement.
  - PRE_A: mcand <= |op_a|, computed via the adder as ~a+1 (cin=1) if negative, else a+0.
  - PRE_B: lo <= |op_b|, computed the same way.
  - The sign flag is op_a[15]^op_b[15], captured at E0.
  - POST_LO: if sign, lo <= ~lo+1 and the carry is saved.
  - POST_HI: hi <= ~hi+carry. When sign=0, both POST states add 0.
  - -32768 is handled because its magnitude 0x8000 fits the unsigned 16-bit datapath.
- MUL_SIGNED_EN undefined: unsigned only, with no PRE/POST states and 16-cycle latency.

## Test plan
- Unsigned: op_a=3, op_b=5, start pulse. Required: busy for 16 cycles, then done pulse with product=0x0000000F, then product holds.
- Unsigned: op_a=0xFFFF, op_b=0xFFFF. Required: product=0xFFFE0001 after 16 cycles, which exercises the cout shift path.
- Busy handling: pulse start with 2×2, then assert start again at iteration 5 with 7×7. Required: a single done pulse with product=0x00000004, and no second operation.
- Reset mid-operation: rst at iteration 8 of 0x1234×0x0010. Required: busy=0, done=0, product=0 on the next cycle; a fresh 1×1 then yields 0x00000001.
- External port: while idle, ext_a=0x1234, ext_b=0x0001, ext_cin=1. Required: ext_gnt=1, ext_sum=0x1236, ext_cout=0. While busy: ext_gnt=0, ext_sum=0, ext_cout=0.
- Signed (MUL_SIGNED_EN): -3×5 gives 0xFFFFFFF1 after 20 cycles; -32768×-1 gives 0x00008000; 0×-7 gives 0x00000000.

Source files
------------

// File: rtl/alu16_mul_seq.sv
// -----------------------------------------------------------------------------
// alu16_mul_seq
//
// Multi-cycle shift-and-add multiplier sequencer for the ALU16 datapath.
// One 16-bit ripple-carry adder (rip_adder8, LENGTH=16) is shared between:
//   * the multiply sequence, which owns the adder whenever busy=1, and
//   * an external ALU port, which may use it combinationally while idle.
//
// Optional feature (macro MUL_SIGNED_EN):
//   undefined (default): unsigned multiply.
//                        States IDLE -> ITER x16 -> IDLE. Latency 16.
//   defined            : two's-complement multiply. States IDLE -> PRE_A ->
//                        PRE_B -> ITER x16 -> POST_LO -> POST_HI -> IDLE.
//                        Latency 20, independent of operand signs.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous reset, active-high, has priority over start
//   start    in   multiply request, sampled only while busy=0
//   op_a     in   [15:0] multiplicand, captured on the accepting edge
//   op_b     in   [15:0] multiplier, captured on the accepting edge
//   busy     out  multiply in progress
//   done     out  one-cycle pulse, product valid
//   product  out  [31:0] registered result, held until the next completion
//   ext_a    in   [15:0] external adder operand A
//   ext_b    in   [15:0] external adder operand B
//   ext_cin  in   external carry-in
//   ext_gnt  out  adder granted to the external port (= !busy)
//   ext_sum  out  [15:0] adder sum when granted, else 0
//   ext_cout out  adder carry-out when granted, else 0
// -----------------------------------------------------------------------------

// 16-bit ripple-carry adder shared by the sequencer and the external port.
module rip_adder8 #(
  parameter int LENGTH = 16
) (
  input  logic [LENGTH-1:0] i_a,
  input  logic [LENGTH-1:0] i_b,
  input  logic              i_cin,
  output logic [LENGTH-1:0] o_sum,
  output logic              o_cout
);

  // Carry ripples bit by bit through a local variable of the block.
  always_comb begin
    logic c;
    c      = i_cin;
    o_sum  = '0;
    for (int i = 0; i < LENGTH; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ c;
      c        = (i_a[i] & i_b[i]) | (c & (i_a[i] ^ i_b[i]));
    end
    o_cout = c;
  end

endmodule

module alu16_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  input  logic [WIDTH-1:0]   ext_a,
  input  logic [WIDTH-1:0]   ext_b,
  input  logic               ext_cin,
  output logic               ext_gnt,
  output logic [WIDTH-1:0]   ext_sum,
  output logic               ext_cout
);

`ifdef MUL_SIGNED_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRE_A   = 3'd1,
    S_PRE_B   = 3'd2,
    S_ITER    = 3'd3,
    S_POST_LO = 3'd4,
    S_POST_HI = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ITER = 3'd3
  } state_t;
`endif

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t             r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [3:0]         r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] r_product;
`ifdef MUL_SIGNED_EN
  logic               r_sign;   // result sign, op_a[15]^op_b[15] at accept
  logic               r_carry;  // carry from POST_LO into POST_HI
`endif

  // ---------------------------------------------------------------------------
  // Shared adder and its input mux
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] w_add_a;
  logic [WIDTH-1:0] w_add_b;
  logic             w_add_cin;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case/if tree leaves it unassigned and infers a latch.
  always_comb begin
    w_add_a   = ext_a;
    w_add_b   = ext_b;
    w_add_cin = ext_cin;
    if (r_busy) begin
      // Partial-product step: hi + (lo[0] ? mcand : 0).
      w_add_a   = r_hi;
      w_add_b   = r_lo[0] ? r_mcand : '0;
      w_add_cin = 1'b0;
`ifdef MUL_SIGNED_EN
      case (r_state)
        // Magnitude: ~x + 1 when negative, x + 0 otherwise.
        S_PRE_A: begin
          w_add_a   = r_mcand[WIDTH-1] ? ~r_mcand : r_mcand;
          w_add_b   = '0;
          w_add_cin = r_mcand[WIDTH-1];
        end
        S_PRE_B: begin
          w_add_a   = r_lo[WIDTH-1] ? ~r_lo : r_lo;
          w_add_b   = '0;
          w_add_cin = r_lo[WIDTH-1];
        end
        // 32-bit negate split over two adder passes; the low-half carry
        // becomes the high-half carry-in. With sign=0 both passes add 0.
        S_POST_LO: begin
          w_add_a   = r_sign ? ~r_lo : r_lo;
          w_add_b   = '0;
          w_add_cin = r_sign;
        end
        S_POST_HI: begin
          w_add_a   = r_sign ? ~r_hi : r_hi;
          w_add_b   = '0;
          w_add_cin = r_sign & r_carry;
        end
        default: ;
      endcase
`endif
    end
  end

  rip_adder8 #(
    .LENGTH (WIDTH)
  ) u_adder (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_cin  (w_add_cin),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // {cout,sum,lo} shifted right by one: the next {hi,lo} after an ITER step.
  logic [2*WIDTH-1:0] w_shifted;
  assign w_shifted = {w_cout, w_sum, r_lo[WIDTH-1:1]};

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
`ifdef MUL_SIGNED_EN
      r_sign    <= 1'b0;
      r_carry   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The done cycle is spent here, so a start held through completion
          // is accepted one edge later, never on the completing edge itself.
          if (start) begin
            r_mcand <= op_a;
            r_lo    <= op_b;
            r_hi    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
`ifdef MUL_SIGNED_EN
            r_sign  <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            r_carry <= 1'b0;
            r_state <= S_PRE_A;
`else
            r_state <= S_ITER;
`endif
          end
        end

`ifdef MUL_SIGNED_EN
        S_PRE_A: begin
          r_mcand <= w_sum;
          r_state <= S_PRE_B;
        end

        S_PRE_B: begin
          r_lo    <= w_sum;
          r_state <= S_ITER;
        end
`endif

        S_ITER: begin
          {r_hi, r_lo} <= w_shifted;
          r_cnt        <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
`ifdef MUL_SIGNED_EN
            r_state   <= S_POST_LO;
`else
            r_product <= w_shifted;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
`endif
          end
        end

`ifdef MUL_SIGNED_EN
        S_POST_LO: begin
          r_lo    <= w_sum;
          r_carry <= w_cout;
          r_state <= S_POST_HI;
        end

        S_POST_HI: begin
          r_hi      <= w_sum;
          r_product <= {w_sum, r_lo};
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
`endif

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy     = r_busy;
  assign done     = r_done;
  assign product  = r_product;

  // External view is combinational from busy and the ext inputs; the sum is
  // forced to zero while the sequencer owns the adder.
  assign ext_gnt  = ~r_busy;
  assign ext_sum  = r_busy ? '0 : w_sum;
  assign ext_cout = ~r_busy & w_cout;

endmodule

// File: tb/tb_alu16_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_alu16_mul_seq
//
// Self-checking bench for alu16_mul_seq. A driver issues multiplies and, for
// each one it expects to be accepted, pushes the reference product and the
// cycle at which done must appear into a scoreboard queue. A monitor sampling
// 1 time unit after every rising edge pops and compares on done, and checks
// busy, product hold, reset values and the external adder port each cycle.
// Define MUL_SIGNED_EN to check the two's-complement build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_alu16_mul_seq;

`ifdef MUL_SIGNED_EN
  localparam int LAT = 20;
`else
  localparam int LAT = 16;
`endif

  typedef struct {
    logic [31:0] prod;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] product;
  logic [15:0] ext_a, ext_b;
  logic        ext_cin;
  logic        ext_gnt;
  logic [15:0] ext_sum;
  logic        ext_cout;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  exp_t        sb[$];
  logic [31:0] last_prod = 32'h0;

  alu16_mul_seq #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .ext_a    (ext_a),
    .ext_b    (ext_b),
    .ext_cin  (ext_cin),
    .ext_gnt  (ext_gnt),
    .ext_sum  (ext_sum),
    .ext_cout (ext_cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference multiply straight from the arithmetic definition.
  function automatic logic [31:0] ref_mul(input logic [15:0] a,
                                          input logic [15:0] b);
`ifdef MUL_SIGNED_EN
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p;
`else
    return {16'h0, a} * {16'h0, b};
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    exp_t        e;
    logic [16:0] ext_ref;
    logic        exp_busy;
    #1;
    if (rst) begin
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_product", product, 32'h0);
      sb.delete();
      last_prod = 32'h0;
    end else begin
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'h0);
        end else begin
          e = sb.pop_front();
          check("product", product, e.prod);
          check("done_cycle", 32'(cyc), 32'(e.cyc));
          last_prod = e.prod;
        end
      end else begin
        check("product_hold", product, last_prod);
      end
      check("busy", 32'(busy), 32'(sb.size() != 0));
    end
    exp_busy = (sb.size() != 0);
    ext_ref  = {1'b0, ext_a} + {1'b0, ext_b} + {16'h0, ext_cin};
    check("ext_gnt", 32'(ext_gnt), 32'(!exp_busy));
    check("ext_sum", 32'(ext_sum), exp_busy ? 32'h0 : 32'(ext_ref[15:0]));
    check("ext_cout", 32'(ext_cout), exp_busy ? 32'h0 : 32'(ext_ref[16]));
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  // Holds start until the DUT is idle, then the next edge is the accepting one.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      check("accept_timeout", 32'(busy), 32'h0);
    end else begin
      e.prod = ref_mul(a, b);
      e.cyc  = cyc + 1 + LAT;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    op_a  = 16'(~a);
    op_b  = 16'(~b);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'h0);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    op_a    = 16'h0;
    op_b    = 16'h0;
    ext_a   = 16'h0;
    ext_b   = 16'h0;
    ext_cin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic unsigned patterns.
    issue(16'd3, 16'd5);
    wait_idle();
    issue(16'hFFFF, 16'hFFFF);
    wait_idle();

    // External port while idle.
    @(negedge clk);
    ext_a   = 16'h1234;
    ext_b   = 16'h0001;
    ext_cin = 1'b1;
    #1;
    check("ext_idle_gnt", 32'(ext_gnt), 32'h1);
    check("ext_idle_sum", 32'(ext_sum), 32'h1236);
    check("ext_idle_cout", 32'(ext_cout), 32'h0);

    // start during busy is ignored; external port locked out meanwhile.
    issue(16'd2, 16'd2);
    repeat (4) @(negedge clk);
    op_a  = 16'd7;
    op_b  = 16'd7;
    start = 1'b1;
    #1;
    check("ext_busy_gnt", 32'(ext_gnt), 32'h0);
    check("ext_busy_sum", 32'(ext_sum), 32'h0);
    check("ext_busy_cout", 32'(ext_cout), 32'h0);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // start held through the done cycle: accepted one edge after completion.
    issue(16'h00FF, 16'h0101);
    issue(16'h8001, 16'h0003);
    wait_idle();

    // Reset in the middle of an operation, then a fresh 1x1.
    issue(16'h1234, 16'h0010);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    issue(16'd1, 16'd1);
    wait_idle();

    // Sign-sensitive patterns (plain unsigned products in the default build).
    issue(16'hFFFD, 16'd5);
    issue(16'h8000, 16'hFFFF);
    issue(16'h0000, 16'hFFF9);
    issue(16'h8000, 16'h8000);
    wait_idle();

    // Randomized operands and external-port traffic.
    for (int i = 0; i < 24; i++) begin
      ext_a   = 16'($urandom);
      ext_b   = 16'($urandom);
      ext_cin = 1'($urandom);
      issue(16'($urandom), 16'($urandom));
      if ($urandom_range(0, 2) == 0) wait_idle();
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
